// File: rtl/tone_sequencer_if.sv
// Handshake and bus bundle for tone_sequencer: control, note-table write port,
// note offer handshake and status. The controller/bench side uses master.
interface tone_sequencer_if;
  logic        start;
  logic        stop;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [10:0] wr_data;
  logic        note_ready;
  logic        note_valid;
  logic [6:0]  note_inc;
  logic        gate;
  logic        busy;
  logic [4:0]  step;
  logic        done;

  modport master (
    output start, stop, wr_en, wr_addr, wr_data, note_ready,
    input  note_valid, note_inc, gate, busy, step, done
  );

  modport slave (
    input  start, stop, wr_en, wr_addr, wr_data, note_ready,
    output note_valid, note_inc, gate, busy, step, done
  );
endinterface

// File: rtl/tone_sequencer.sv
// Note-table driven tone sequencer: walks a 32-entry table, offers each note to a
// tone generator, then gates it for its duration followed by a silent space.
// Define TONE_SEQ_LOOP_EN to loop the pass endlessly instead of stopping with done.
//
// state | meaning
// IDLE  | waiting for start; step holds its last value
// FETCH | latch table[step] into the note registers
// ISSUE | offer note_inc until the generator accepts it
// NOTE  | gate open (unless rest) for (dur+1)*TICK_CYCLES cycles
// SPACE | gate closed for SPACE_TICKS*TICK_CYCLES cycles, then next step
module tone_sequencer #(
  parameter int TICK_CYCLES = 125,
  parameter int SPACE_TICKS = 1
) (
  input  logic           clk,
  input  logic           rst,
  tone_sequencer_if.slave bus
);

  localparam int NOTE_MAX  = 8 * TICK_CYCLES;
  localparam int SPACE_LEN = SPACE_TICKS * TICK_CYCLES;
  localparam int CNT_MAX   = (NOTE_MAX > SPACE_LEN) ? NOTE_MAX : SPACE_LEN;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, NOTE, SPACE} state_t;

  localparam cnt_t SPACE_LOAD = cnt_t'(SPACE_LEN - 1);

  // Down-counter load values: the phase ends when the counter reaches zero.
  function automatic cnt_t note_load(input logic [2:0] dur);
    return cnt_t'((int'(dur) + 1) * TICK_CYCLES - 1);
  endfunction

  logic [10:0] tab [32];
  state_t      state;
  cnt_t        cnt;
  logic [4:0]  step_r;
  logic [2:0]  note_dur;
  logic        note_end;
  logic [6:0]  inc_r;
  logic        valid_r;
  logic        gate_r;
  logic        busy_r;
  logic        done_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) tab[i] <= '0;
    end else if (bus.wr_en) begin
      tab[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      step_r   <= '0;
      note_dur <= '0;
      note_end <= 1'b0;
      inc_r    <= '0;
      valid_r  <= 1'b0;
      gate_r   <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.stop && state != IDLE) begin
        state   <= IDLE;
        cnt     <= '0;
        valid_r <= 1'b0;
        gate_r  <= 1'b0;
        busy_r  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.stop) begin
              state  <= FETCH;
              step_r <= '0;
              busy_r <= 1'b1;
            end
          end
          FETCH: begin
            {note_end, note_dur, inc_r} <= tab[step_r];
            valid_r <= 1'b1;
            state   <= ISSUE;
          end
          ISSUE: begin
            if (valid_r && bus.note_ready) begin
              valid_r <= 1'b0;
              gate_r  <= (inc_r != '0);
              cnt     <= note_load(note_dur);
              state   <= NOTE;
            end
          end
          NOTE: begin
            if (cnt == '0) begin
              gate_r <= 1'b0;
              cnt    <= SPACE_LOAD;
              state  <= SPACE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          SPACE: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (!note_end && step_r != 5'd31) begin
              step_r <= step_r + 5'd1;
              state  <= FETCH;
            end else begin
`ifdef TONE_SEQ_LOOP_EN
              step_r <= '0;
              state  <= FETCH;
`else
              state  <= IDLE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.note_valid = valid_r;
  assign bus.note_inc   = inc_r;
  assign bus.gate       = gate_r;
  assign bus.busy       = busy_r;
  assign bus.step       = step_r;
  assign bus.done       = done_r;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer (TICK_CYCLES=4, SPACE_TICKS=1); honours
// TONE_SEQ_LOOP_EN the same way the design does.
module tb_tone_sequencer;
  localparam int TICK  = 4;
  localparam int SPACE = 1;

  logic clk = 1'b0;
  logic rst;
  tone_sequencer_if bus ();

  tone_sequencer #(.TICK_CYCLES(TICK), .SPACE_TICKS(SPACE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [10:0] mdl_tab [32];

  typedef struct {
    logic       valid;
    logic [6:0] inc;
    logic       gate;
    logic       busy;
    logic [4:0] step;
    logic       done;
    logic       chk_inc;
    logic       rdy;
    logic       stp;
  } exp_t;
  exp_t tq[$];

  typedef struct {
    int dur;
    int inc;
    int wait_cyc;
    int exp_gate;
    int exp_busy;
  } vec_t;
  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [10:0] ent(input bit e, input int dur, input int inc);
    return {e, 3'(dur), 7'(inc)};
  endfunction

  task automatic wr(input int a, input logic [10:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'(a);
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    mdl_tab[a] = d;
  endtask

  function automatic void push(input bit v, input int inc, input bit g, input bit b,
                               input int s, input bit d, input bit ci, input bit r, input bit st);
    exp_t x;
    x.valid = v; x.inc = 7'(inc); x.gate = g; x.busy = b; x.step = 5'(s);
    x.done = d; x.chk_inc = ci; x.rdy = r; x.stp = st;
    tq.push_back(x);
  endfunction

  // Expected timeline of one pass, built from the table contents and the playback rules.
  task automatic build(input int max_wait);
    int s, dur, inc, w;
    bit fin;
    logic [10:0] e;
    tq.delete();
    s = 0;
    fin = 1'b0;
    while (!fin) begin
      e   = mdl_tab[s];
      dur = int'(e[9:7]);
      inc = int'(e[6:0]);
      w   = int'($urandom_range(max_wait, 0));
      push(0, 0, 0, 1, s, 0, 0, 1'($urandom_range(1, 0)), 0);
      for (int j = 0; j <= w; j++) push(1, inc, 0, 1, s, 0, 1, (j == w), 0);
      for (int j = 0; j < (dur + 1) * TICK; j++)
        push(0, inc, (inc != 0), 1, s, 0, 1, 1'($urandom_range(1, 0)), 0);
      for (int j = 0; j < SPACE * TICK; j++)
        push(0, inc, 0, 1, s, 0, 1, 1'($urandom_range(1, 0)), 0);
      if (e[10] || s == 31) fin = 1'b1;
      else s++;
    end
`ifdef TONE_SEQ_LOOP_EN
    push(0, 0, 0, 1, 0, 0, 0, 0, 1);
    push(0, 0, 0, 0, 0, 0, 0, 0, 0);
`else
    push(0, 0, 0, 0, s, 1, 0, 0, 0);
    push(0, 0, 0, 0, s, 0, 0, 0, 0);
`endif
  endtask

  task automatic run_trace(input string name);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < tq.size(); i++) begin
      n_tests++;
      if (bus.note_valid !== tq[i].valid || bus.gate !== tq[i].gate || bus.busy !== tq[i].busy ||
          bus.step !== tq[i].step || bus.done !== tq[i].done ||
          (tq[i].chk_inc && bus.note_inc !== tq[i].inc)) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got v=%0b inc=%0d g=%0b b=%0b s=%0d d=%0b, expected v=%0b inc=%0d g=%0b b=%0b s=%0d d=%0b",
                 name, i, bus.note_valid, bus.note_inc, bus.gate, bus.busy, bus.step, bus.done,
                 tq[i].valid, tq[i].inc, tq[i].gate, tq[i].busy, tq[i].step, tq[i].done);
      end
      bus.note_ready = tq[i].rdy;
      bus.stop       = tq[i].stp;
      if (i != tq.size() - 1) tick();
    end
    bus.stop = 1'b0;
    bus.note_ready = 1'b0;
    tick();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_valid"}, bus.note_valid, 0);
    check({pfx, "_inc"},   bus.note_inc,   0);
    check({pfx, "_gate"},  bus.gate,       0);
    check({pfx, "_busy"},  bus.busy,       0);
    check({pfx, "_step"},  bus.step,       0);
    check({pfx, "_done"},  bus.done,       0);
  endtask

  initial begin
    int g, b, inc_seen, len;
    rst = 1'b1;
    bus.start = 0; bus.stop = 0; bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.note_ready = 0;
    for (int i = 0; i < 32; i++) mdl_tab[i] = '0;
    tick(); tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Single-entry programs: {dur, inc, ready wait, gate-high cycles, busy cycles}
    vecs[0] = '{1, 67, 0, 8, 14};
    vecs[1] = '{0, 40, 0, 4, 10};
    vecs[2] = '{2, 0, 0, 0, 18};
    vecs[3] = '{7, 127, 2, 32, 40};
    vecs[4] = '{1, 67, 10, 8, 24};
    vecs[5] = '{3, 1, 1, 16, 23};
    for (int v = 0; v < 6; v++) begin
      wr(0, ent(1, vecs[v].dur, vecs[v].inc));
      bus.note_ready = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      g = 0; b = 0; inc_seen = -1;
      for (int c = 0; c < vecs[v].exp_busy; c++) begin
        if (bus.busy === 1'b1) b++;
        if (bus.gate === 1'b1) g++;
        if (bus.note_valid === 1'b1 && inc_seen < 0) inc_seen = int'(bus.note_inc);
        if (c >= 1 + vecs[v].wait_cyc) bus.note_ready = 1'b1;
        tick();
      end
      check($sformatf("vec%0d_busy_cycles", v), b, vecs[v].exp_busy);
      check($sformatf("vec%0d_gate_cycles", v), g, vecs[v].exp_gate);
      check($sformatf("vec%0d_inc", v), inc_seen, vecs[v].inc);
`ifdef TONE_SEQ_LOOP_EN
      check($sformatf("vec%0d_wrap_busy", v), bus.busy, 1);
      check($sformatf("vec%0d_wrap_step", v), bus.step, 0);
      check($sformatf("vec%0d_wrap_done", v), bus.done, 0);
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
`else
      check($sformatf("vec%0d_end_busy", v), bus.busy, 0);
      check($sformatf("vec%0d_end_done", v), bus.done, 1);
      tick();
      check($sformatf("vec%0d_done_pulse", v), bus.done, 0);
`endif
      bus.note_ready = 1'b0;
      tick();
    end

    // Two-entry reference program
    wr(0, ent(0, 1, 67));
    wr(1, ent(1, 0, 40));
    build(0);
    run_trace("two_note");
    build(3);
    run_trace("two_note_slow_ready");

    // stop during NOTE, then start+stop together from IDLE
    bus.note_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    check("gate_in_note", bus.gate, 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("stop_busy", bus.busy, 0);
    check("stop_gate", bus.gate, 0);
    check("stop_valid", bus.note_valid, 0);
    check("stop_done", bus.done, 0);
    bus.start = 1'b1;
    bus.stop = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop = 1'b0;
    check("start_stop_busy", bus.busy, 0);
    tick();
    check("start_stop_busy_later", bus.busy, 0);
    check("start_stop_done", bus.done, 0);

    // stop during ISSUE withdraws the offer
    bus.note_ready = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("offer_valid", bus.note_valid, 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("withdraw_valid", bus.note_valid, 0);
    check("withdraw_busy", bus.busy, 0);
    tick();
    check("withdraw_gate", bus.gate, 0);

    // A write to the step being fetched is not seen by that fetch
    wr(0, ent(1, 0, 67));
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = ent(1, 0, 40);
    tick();
    bus.wr_en = 1'b0;
    mdl_tab[0] = ent(1, 0, 40);
    check("fetch_write_old_inc", bus.note_inc, 67);
    check("fetch_write_valid", bus.note_valid, 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    build(1);
    run_trace("fetch_write_seen");

    // Randomised programs; the last trial has no end flag and runs to step 31
    for (int t = 0; t < 5; t++) begin
      len = (t == 4) ? 32 : int'($urandom_range(6, 1));
      for (int k = 0; k < len; k++)
        wr(k, ent((t != 4) && (k == len - 1), int'($urandom_range(7, 0)),
                  ($urandom_range(3, 0) == 0) ? 0 : int'($urandom_range(127, 1))));
      build(3);
      run_trace($sformatf("rand%0d", t));
    end

    // rst mid-NOTE overrides start/stop/wr_en and clears the table
    wr(0, ent(0, 3, 99));
    bus.note_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    bus.start = 1'b1; bus.stop = 1'b1;
    bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = ent(1, 7, 55);
    tick();
    rst = 1'b0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.wr_en = 1'b0; bus.note_ready = 1'b0;
    check_reset_outputs("midrst");
    for (int i = 0; i < 32; i++) mdl_tab[i] = '0;
    build(0);
    run_trace("zero_walk");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 125, meaning clocks per duration tick (min 1).
REQ-002 SHALL have parameter SPACE_TICKS, default 1, meaning ticks of silence after every note (min 1).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-005 SHALL have port start  input  1  begin playback from step 0.
REQ-006 SHALL have port stop  input  1  abort playback.
REQ-007 SHALL have port wr_en  input  1  note-table write strobe.
REQ-008 SHALL have port wr_addr  input  5  note-table index.
REQ-009 SHALL have port wr_data  input  11  entry {end[10], dur[9:7], inc[6:0]}.
REQ-010 SHALL have port note_ready  input  1  tone generator accepts the offered note.
REQ-011 SHALL have port note_valid  output  1  note offer to the tone generator.
REQ-012 SHALL have port note_inc  output  7  phase increment of the offered or playing note.
REQ-013 SHALL have port gate  output  1  tone generator audible enable.
REQ-014 SHALL have port busy  output  1  sequencer not IDLE.
REQ-015 SHALL have port step  output  5  current table index.
REQ-016 SHALL have port done  output  1  one-cycle pulse at end of a non-looping pass.

Function
REQ-017 SHALL hold a 32-entry by 11-bit note table; wr_en writes wr_data to wr_addr on the same edge, in any state.
REQ-018 SHALL implement states IDLE, FETCH, ISSUE, NOTE, SPACE.
REQ-019 IDLE: on start, go to FETCH with step=0; otherwise stay.
REQ-020 FETCH: latch table[step] into note registers (1 cycle), then go to ISSUE; a write to the same step on that edge is not seen.
REQ-021 ISSUE: note_valid=1, note_inc=latched inc, held stable until note_valid&&note_ready; on handshake go to NOTE and clear the cycle counter.
REQ-022 NOTE: lasts exactly (dur+1)*TICK_CYCLES cycles; gate=1 unless inc==0 (rest, gate=0).
REQ-023 SPACE: lasts exactly SPACE_TICKS*TICK_CYCLES cycles with gate=0, then the end-of-step action of REQ-024.
REQ-024 End of step: if end==0 and step!=31, step+1 and go to FETCH; if end==1 or step==31, apply the configured wrap rule (REQ-031/032).
REQ-025 Duration counter SHALL be wide enough for 8*TICK_CYCLES without overflow; comparisons exact, no off-by-one.
REQ-026 stop in any non-IDLE state: next state IDLE, note_valid=0, gate=0, no done pulse; any pending offer is withdrawn without handshake.
REQ-027 start and stop asserted together: stop wins; start while busy is ignored.
REQ-028 busy=1 in every state except IDLE; step holds its last value in IDLE.

Reset
REQ-029 On rst: state IDLE, step=0, note_valid=0, note_inc=0, gate=0, busy=0, done=0, counters 0, all table entries 0.
REQ-030 rst mid-playback SHALL take precedence over start, stop and wr_en that cycle.

Configuration
REQ-031 With macro TONE_SEQ_LOOP_EN defined, the end-of-pass action SHALL set step=0 and go to FETCH (endless loop), and done SHALL stay 0.
REQ-032 Without TONE_SEQ_LOOP_EN, the end-of-pass action SHALL go to IDLE and pulse done for one cycle, coincident with busy falling.

Verification (TICK_CYCLES=4, SPACE_TICKS=1; entry0={0,1,67}, entry1={1,0,40})
REQ-033 start pulse at cycle T, note_ready=1 -> FETCH at T+1, note_valid with inc 67 at T+2, gate high 8 cycles, low 4, then note_valid with inc 40, gate high 4 cycles, low 4.
REQ-034 Same, without macro -> done=1 for exactly one cycle after the entry1 space, busy=0 and step=1 afterwards; with macro -> step=0 and note_valid with inc 67 again, done never asserted.
REQ-035 note_ready held 0 for 10 cycles in ISSUE -> note_valid stays 1, note_inc stays 67, gate stays 0; gate rises the cycle after ready.
REQ-036 entry0 inc=0, dur=2 -> gate stays 0 for 12+4 cycles while busy=1, then entry1 plays normally.
REQ-037 stop during NOTE of entry0 -> next cycle busy=0, gate=0, note_valid=0, done=0; start with stop the same cycle from IDLE -> busy stays 0.
REQ-038 rst asserted for one cycle mid-NOTE -> all outputs at reset values; a subsequent start plays zeroed entries: one rest of 4 cycles each per step, advancing to step 31, then the wrap rule applies.
